// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
//
// Multi-mode shift register with a two-state (IDLE/SHIFT) sequencer.
// A start in IDLE either completes at once (LOAD, HOLD, reserved, or a shift
// of zero bits) or latches the mode and shift count and then performs one
// single-bit shift per clock until the count runs out.
//
// Optional feature: define USR_PARITY_EN to add the 'parity' output, the XOR
// of all q bits.
//
// Parameters
//   WIDTH   register width in bits (>= 2)
//   CNT_W   width of the shift-amount input
//
// Ports
//   clk      clock, rising edge
//   reset    synchronous, active-high reset
//   mode     operation select: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//            100 ROL, 101 ROR, 110 ASR, 111 reserved (HOLD)
//   start    operation request, accepted only in IDLE
//   amount   number of single-bit shifts
//   d        parallel load data
//   sin_l    serial input entering the LSB on SHL
//   sin_r    serial input entering the MSB on SHR
//   q        register contents
//   sout_l   q[WIDTH-1]
//   sout_r   q[0]
//   parity   XOR of q (only with USR_PARITY_EN)
//   busy     multi-cycle shift in progress
//   done     one-cycle completion pulse
// ---------------------------------------------------------------------------
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
`ifdef USR_PARITY_EN
    output logic             parity,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_mode;
    logic             r_busy;
    logic             r_done;

    logic             w_is_shift_mode;
    logic [WIDTH-1:0] w_q_next_shift;

    // Single-bit step of the selected shift kind; anything else holds.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [2:0]       f_mode,
        input logic [WIDTH-1:0] f_val,
        input logic             f_sin_l,
        input logic             f_sin_r
    );
        case (f_mode)
            M_SHL:   shift_one = {f_val[WIDTH-2:0], f_sin_l};
            M_SHR:   shift_one = {f_sin_r, f_val[WIDTH-1:1]};
            M_ROL:   shift_one = {f_val[WIDTH-2:0], f_val[WIDTH-1]};
            M_ROR:   shift_one = {f_val[0], f_val[WIDTH-1:1]};
            M_ASR:   shift_one = {f_val[WIDTH-1], f_val[WIDTH-1:1]};
            default: shift_one = f_val;
        endcase
    endfunction

    assign w_is_shift_mode = (mode >= M_SHL) && (mode <= M_ASR);
    assign w_q_next_shift  = shift_one(r_mode, r_q, sin_l, sin_r);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours; blocking here would make
    // the result depend on statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= M_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (mode == M_LOAD) begin
                            r_q    <= d;
                            r_done <= 1'b1;
                        end else if (w_is_shift_mode && (amount != CNT_ZERO)) begin
                            // q is left untouched on the accepting edge; the
                            // first shift happens on the next one.
                            r_mode  <= mode;
                            r_cnt   <= amount;
                            r_busy  <= 1'b1;
                            r_state <= SHIFT;
                        end else begin
                            // HOLD, reserved, or a zero-length shift.
                            r_done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_q   <= w_q_next_shift;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = r_busy;
    assign done   = r_done;

`ifdef USR_PARITY_EN
    assign parity = ^r_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_register
//
// Directed and randomized operations on an 8-bit / 4-bit-count instance.
// Expected register contents come from an arithmetic model of each mode
// applied N times at once (shift, rotate modulo width, signed shift), and
// the busy/done timeline is checked cycle by cycle. Define USR_PARITY_EN to
// also exercise the parity output.
// ---------------------------------------------------------------------------
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;

    localparam logic [2:0] HOLD = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] SHR  = 3'd3;
    localparam logic [2:0] ROL  = 3'd4;
    localparam logic [2:0] ROR  = 3'd5;
    localparam logic [2:0] ASR  = 3'd6;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    mode;
    logic          start;
    logic [CW-1:0] amount;
    logic [W-1:0]  d;
    logic          sin_l;
    logic          sin_r;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
`ifdef USR_PARITY_EN
    logic          parity;
`endif
    logic          busy;
    logic          done;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [W-1:0]  exp_q  = '0;

    universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .start  (start),
        .amount (amount),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
`ifdef USR_PARITY_EN
        .parity (parity),
`endif
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Result of applying mode m n times to v, computed in one step.
    function automatic logic [W-1:0] model(input logic [2:0] m, input int n,
                                           input logic [W-1:0] v,
                                           input logic sl, input logic sr);
        int unsigned       vi;
        int unsigned       r;
        int                k;
        logic signed [W-1:0] s;
        vi = v;
        k  = n % W;
        case (m)
            SHL: r = (n >= W) ? (sl ? 32'hFF : 32'h0)
                              : ((vi << n) | (sl ? ((32'd1 << n) - 1) : 32'd0));
            SHR: r = (n >= W) ? (sr ? 32'hFF : 32'h0)
                              : ((vi >> n) | (sr ? (32'hFF << (W - n)) : 32'd0));
            ROL: r = (vi << k) | (vi >> (W - k));
            ROR: r = (vi >> k) | (vi << (W - k));
            ASR: begin
                s = v;
                s = s >>> n;
                r = {24'd0, s};
            end
            default: r = vi;
        endcase
        return r[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_q(input string tag);
        check({tag, ".q"}, {24'd0, q}, {24'd0, exp_q});
        check({tag, ".sout_l"}, {31'd0, sout_l}, {31'd0, exp_q[W-1]});
        check({tag, ".sout_r"}, {31'd0, sout_r}, {31'd0, exp_q[0]});
`ifdef USR_PARITY_EN
        check({tag, ".parity"}, {31'd0, parity}, {31'd0, ^exp_q});
`endif
    endtask

    task automatic check_flags(input string tag, input logic eb, input logic ed);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        check({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // poke: 0 = quiet while busy, 1 = random junk on inputs while busy,
    // 2 = assert start with LOAD throughout the shift.
    // idle_after = 0 leaves the bench in the done cycle so the next call
    // starts back-to-back.
    task automatic do_op(input string tag, input logic [2:0] m, input int n,
                         input logic [W-1:0] dv, input logic sl, input logic sr,
                         input int poke, input bit idle_after);
        logic [W-1:0] q0;
        bit           multi;
        q0     = exp_q;
        multi  = (m >= SHL) && (m <= ASR) && (n != 0);
        mode   = m;
        amount = n[CW-1:0];
        d      = dv;
        sin_l  = sl;
        sin_r  = sr;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        if (multi) begin
            for (int k = 0; k < n; k++) begin
                exp_q = model(m, k, q0, sl, sr);
                check_flags({tag, ".run"}, 1'b1, 1'b0);
                check_q({tag, ".run"});
                if (poke == 1) begin
                    start  = 1'($urandom_range(0, 1));
                    mode   = 3'($urandom_range(0, 7));
                    amount = CW'($urandom_range(0, 15));
                    d      = W'($urandom);
                end else if (poke == 2) begin
                    start = 1'b1;
                    mode  = LOAD;
                    d     = W'($urandom);
                end
                tick();
            end
            start = 1'b0;
            exp_q = model(m, n, q0, sl, sr);
        end else if (m == LOAD) begin
            exp_q = dv;
        end
        check_flags({tag, ".end"}, 1'b0, 1'b1);
        check_q({tag, ".end"});
        if (idle_after) begin
            tick();
            check_flags({tag, ".idle"}, 1'b0, 1'b0);
            check_q({tag, ".idle"});
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mode   = HOLD;
        amount = '0;
        d      = '0;
        sin_l  = 1'b0;
        sin_r  = 1'b0;
        tick();
        tick();
        exp_q = '0;
        check_flags("reset", 1'b0, 1'b0);
        check_q("reset");
        reset = 1'b0;
        tick();
        check_flags("post_reset", 1'b0, 1'b0);

        // Load, then shift left three with ones entering.
        do_op("load_a5", LOAD, 0, 8'hA5, 1'b0, 1'b0, 0, 1'b1);
        do_op("shl3", SHL, 3, 8'h00, 1'b1, 1'b0, 0, 1'b1);
        check("shl3_2f", {24'd0, q}, 32'h2F);

        // Rotate right and arithmetic shift right.
        do_op("load_81", LOAD, 0, 8'h81, 1'b0, 1'b0, 0, 1'b1);
        do_op("ror1", ROR, 1, 8'h00, 1'b0, 1'b0, 0, 1'b1);
        check("ror1_c0", {24'd0, q}, 32'hC0);
        do_op("load_80", LOAD, 0, 8'h80, 1'b0, 1'b0, 0, 1'b1);
        do_op("asr2", ASR, 2, 8'h00, 1'b0, 1'b0, 0, 1'b1);
        check("asr2_e0", {24'd0, q}, 32'hE0);

        // Zero-length shift, then a 5-shift SHR with start held during it.
        do_op("shr0", SHR, 0, 8'h00, 1'b0, 1'b1, 0, 1'b1);
        do_op("load_3c", LOAD, 0, 8'h3C, 1'b0, 1'b0, 0, 1'b1);
        do_op("shr5", SHR, 5, 8'h00, 1'b0, 1'b1, 2, 1'b1);

        // Reserved mode, long amounts, back-to-back starts.
        do_op("rsvd", 3'b111, 7, 8'hFF, 1'b1, 1'b1, 0, 1'b1);
        do_op("load_b2", LOAD, 0, 8'hB2, 1'b0, 1'b0, 0, 1'b0);
        do_op("rol11", ROL, 11, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        do_op("shl15", SHL, 15, 8'h00, 1'b0, 1'b0, 1, 1'b1);

        // Reset arriving on the second shift edge of a 6-shift SHL.
        do_op("load_5a", LOAD, 0, 8'h5A, 1'b0, 1'b0, 0, 1'b1);
        mode   = SHL;
        amount = 4'd6;
        sin_l  = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q = '0;
        check_flags("abort", 1'b0, 1'b0);
        check_q("abort");
        for (int k = 0; k < 8; k++) begin
            tick();
            check_flags("abort_quiet", 1'b0, 1'b0);
        end
        check_q("abort_quiet");

`ifdef USR_PARITY_EN
        do_op("par_07", LOAD, 0, 8'h07, 1'b0, 1'b0, 0, 1'b1);
        check("parity_1", {31'd0, parity}, 32'd1);
        do_op("par_03", LOAD, 0, 8'h03, 1'b0, 1'b0, 0, 1'b1);
        check("parity_0", {31'd0, parity}, 32'd0);
`endif

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            do_op("rand", 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                  W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        tick();
        check_flags("final", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 Parameter CNT_W, default 4: width of the shift-amount input.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port mode, input, 3: operation select; encoding is given in REQ-013.
REQ-006 Port start, input, 1: request an operation; accepted only in IDLE.
REQ-007 Port amount, input, CNT_W: number of single-bit shifts to perform.
REQ-008 Port d, input, WIDTH: parallel load data.
REQ-009 Port sin_l, input, 1: serial input that enters the LSB on SHL.
REQ-010 Port sin_r, input, 1: serial input that enters the MSB on SHR.
REQ-011 Port q, output, WIDTH: register contents. Port sout_l, output, 1: q[WIDTH-1]. Port sout_r, output, 1: q[0]. sout_l and sout_r are combinational from q.
REQ-012 Port busy, output, 1: a multi-cycle shift is in progress. Port done, output, 1: one-cycle completion pulse.

Function
REQ-013 Mode encoding:
- 000 HOLD
- 001 LOAD
- 010 SHL (sin_l enters LSB)
- 011 SHR (sin_r enters MSB)
- 100 ROL
- 101 ROR
- 110 ASR (MSB replicated)
- 111 reserved, behaves as HOLD.
REQ-014 The FSM has exactly two states, IDLE and SHIFT; only IDLE accepts start.
REQ-015 IDLE, start=1, mode=LOAD: q <= d on the accepting edge; done=1 for the following cycle; busy stays 0.
REQ-016 IDLE, start=1, mode=HOLD/reserved, or any shift mode with amount=0: q unchanged; done=1 for the following cycle; busy stays 0.
REQ-017 IDLE, start=1, shift mode, amount=N>0: on the accepting edge, mode and N are latched into an internal counter and the FSM goes to SHIFT; busy=1 from the next cycle; q is unchanged on that edge.
REQ-018 In SHIFT, each edge performs one single-bit shift of the latched mode and decrements the counter; sin_l and sin_r are sampled on each shift edge.
REQ-019 On the edge that performs the Nth shift: the FSM returns to IDLE, busy=0, and done=1 for one cycle with the final q already valid.
REQ-020 Cycle timing: start accepted at edge 0; shifts occur at edges 1..N; done is high only in the cycle after edge N.
REQ-021 mode, amount and d changes while busy are ignored; start while busy is ignored and is not queued.
REQ-022 A start presented in the cycle that done is high is accepted normally (back-to-back operation).
REQ-023 Maximum amount is 2^CNT_W-1. Amounts at or above WIDTH are legal; SHL/SHR fully flush q, rotates wrap modulo WIDTH.
REQ-024 done and busy are never high in the same cycle.

Reset
REQ-025 reset=1 at an edge sets q=0, FSM=IDLE, counter=0, busy=0, done=0.
REQ-026 reset has priority over start and over an in-progress shift.
REQ-027 A reset during SHIFT aborts the operation and no done pulse is issued for it.

Configuration
REQ-028 Macro USR_PARITY_EN, when defined, adds output parity (1 bit) equal to the XOR of all q bits, combinational, 0 after reset.
REQ-029 Without USR_PARITY_EN, the parity port and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8, CNT_W=4)
REQ-030 Reset, then LOAD with d=8'hA5 -> q=8'hA5 after 1 edge, done high 1 cycle, busy never high.
REQ-031 q=8'hA5, SHL, amount=3, sin_l=1 -> busy high 3 cycles, then q=8'h2F with a single done pulse.
REQ-032 q=8'h81, ROR, amount=1 -> q=8'hC0. Then LOAD 8'h80 followed by ASR, amount=2 -> q=8'hE0.
REQ-033 SHR with amount=0 -> done next cycle, q unchanged. During a 5-shift SHR, pulse start with mode=LOAD -> ignored, exactly 5 shifts occur.
REQ-034 reset asserted at the 2nd shift edge of SHL with amount=6 -> q=8'h00, busy=0, no done pulse afterwards.
REQ-035 With USR_PARITY_EN defined, LOAD 8'h07 -> parity=1; LOAD 8'h03 -> parity=0.
